doorlock_ctrl: RTL and testbench

Door-lock sequencer fed directly by the multi-bit key debouncer. Takes the debounced 4-button vector, detects press edges, collects a fixed-length digit code, compares it against a parameterised password, and drives the unlock output for a timed window. It also drives a failure alarm. It sits between the debouncer and the LED/7-segment output logic of the DE0 door-lock design.

---
 rtl/doorlock_pkg.sv | 21 ++
 rtl/key_edge_det.sv | 42 ++++
 rtl/doorlock_ctrl.sv | 159 +++++++++++++++
 tb/tb_doorlock_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - shared state encodings, widths and password digit helper for doorlock_ctrl
package doorlock_pkg;

    localparam int DIGIT_W = 2;
    localparam int TMR_W   = 28;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    // Digit idx of a len-digit code packed first digit in the MSBs
    function automatic logic [DIGIT_W-1:0] pw_digit(input logic [31:0] pw, input int len, input int idx);
        return DIGIT_W'(pw >> ((len - 1 - idx) * DIGIT_W));
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - key rise detection, one-hot check and digit encoder
module key_edge_det
    import doorlock_pkg::*;
#(
    parameter int D_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_W-1:0]     key,
    output logic               press,
    output logic [DIGIT_W-1:0] digit,
    output logic               multi
);

    logic [D_W-1:0] key_d1;
    logic [D_W-1:0] rise;

    // Previous key sample; tracks key in every state so held keys never re-trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            key_d1 <= '0;
        end else begin
            key_d1 <= key;
        end
    end

    assign rise  = key & ~key_d1;
    assign press = |rise;
    // More than one bit set: clearing the lowest set bit leaves something behind
    assign multi = |(rise & (rise - D_W'(1)));

    // Index of the lowest risen key; only meaningful when the press is one-hot
    always_comb begin
        digit = '0;
        for (int i = D_W - 1; i >= 0; i--) begin
            if (rise[i]) begin
                digit = DIGIT_W'(i);
            end
        end
    end

endmodule

// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - door-lock code sequencer; failure lockout built only with DOORLOCK_LOCKOUT_EN
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int                        D_W       = 4,
    parameter int                        PW_LEN    = 4,
    parameter logic [DIGIT_W*PW_LEN-1:0] PASSWORD  = 8'b00_01_10_11,
    parameter logic [TMR_W-1:0]          T_OPEN    = 28'd150_000_000,
    parameter logic [TMR_W-1:0]          T_ENTRY   = 28'd250_000_000,
    parameter logic [TMR_W-1:0]          T_LOCKOUT = 28'd250_000_000,
    parameter int                        MAX_FAIL  = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [D_W-1:0] key,
    output logic           unlock,
    output logic           alarm,
    output logic [2:0]     digit_cnt,
    output logic           ok_pulse,
    output logic           fail_pulse
);

    logic               press;
    logic               multi;
    logic [DIGIT_W-1:0] digit;
    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic               mismatch;
    logic               digit_bad;
    logic [2:0]         cnt_next;
    logic               last_digit;

    key_edge_det #(.D_W(D_W)) u_key_edge_det (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press),
        .digit (digit),
        .multi (multi)
    );

    // A multi-key press is always wrong; otherwise compare against the digit at this position
    assign digit_bad  = multi || (digit != pw_digit(32'(PASSWORD), PW_LEN, int'(digit_cnt)));
    assign cnt_next   = digit_cnt + 3'd1;
    assign last_digit = (cnt_next == 3'(PW_LEN));

`ifdef DOORLOCK_LOCKOUT_EN
    logic [7:0] fail_cnt;
`else
    assign alarm = 1'b0;
`endif

    // Sequencer: collects digits, judges the code and times the open/lockout windows
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            digit_cnt  <= '0;
            timer      <= '0;
            mismatch   <= 1'b0;
            unlock     <= 1'b0;
            ok_pulse   <= 1'b0;
            fail_pulse <= 1'b0;
`ifdef DOORLOCK_LOCKOUT_EN
            fail_cnt   <= '0;
            alarm      <= 1'b0;
`endif
        end else begin
            ok_pulse   <= 1'b0;
            fail_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state     <= last_digit ? ST_CHECK : ST_ENTRY;
                        digit_cnt <= cnt_next;
                        mismatch  <= digit_bad;
                        timer     <= T_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (press) begin
                        if (last_digit) begin
                            state <= ST_CHECK;
                        end
                        digit_cnt <= cnt_next;
                        mismatch  <= mismatch | digit_bad;
                        timer     <= T_ENTRY;
                    end else if (timer <= TMR_W'(1)) begin
                        // Abandoned attempt: not a failure
                        state     <= ST_IDLE;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_CHECK: begin
                    digit_cnt <= '0;
                    mismatch  <= 1'b0;
                    if (!mismatch) begin
                        state    <= ST_OPEN;
                        ok_pulse <= 1'b1;
                        unlock   <= 1'b1;
                        timer    <= T_OPEN;
`ifdef DOORLOCK_LOCKOUT_EN
                        fail_cnt <= '0;
`endif
                    end else begin
                        state      <= ST_FAIL;
                        fail_pulse <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (timer <= TMR_W'(1)) begin
                        state  <= ST_IDLE;
                        unlock <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_FAIL: begin
`ifdef DOORLOCK_LOCKOUT_EN
                    if (fail_cnt < 8'(MAX_FAIL)) begin
                        fail_cnt <= fail_cnt + 8'd1;
                    end
                    if (fail_cnt + 8'd1 >= 8'(MAX_FAIL)) begin
                        state <= ST_LOCKOUT;
                        alarm <= 1'b1;
                        timer <= T_LOCKOUT;
                    end else begin
                        state <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_LOCKOUT: begin
`ifdef DOORLOCK_LOCKOUT_EN
                    if (timer <= TMR_W'(1)) begin
                        state    <= ST_IDLE;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                        timer    <= '0;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - scoreboard bench for doorlock_ctrl with a timestamp-based reference model
module tb_doorlock_ctrl;

    localparam int         PW_LEN    = 4;
    localparam logic [7:0] PW        = 8'b00_01_10_11;
    localparam logic [7:0] WRONG     = 8'b00_01_10_10;
    localparam int         T_OPEN    = 10;
    localparam int         T_ENTRY   = 20;
    localparam int         T_LOCKOUT = 30;
    localparam int         MAX_FAIL  = 3;
`ifdef DOORLOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       unlock;
    logic       alarm;
    logic [2:0] digit_cnt;
    logic       ok_pulse;
    logic       fail_pulse;

    doorlock_ctrl #(
        .D_W       (4),
        .PW_LEN    (PW_LEN),
        .PASSWORD  (PW),
        .T_OPEN    (28'(T_OPEN)),
        .T_ENTRY   (28'(T_ENTRY)),
        .T_LOCKOUT (28'(T_LOCKOUT)),
        .MAX_FAIL  (MAX_FAIL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .unlock     (unlock),
        .alarm      (alarm),
        .digit_cnt  (digit_cnt),
        .ok_pulse   (ok_pulse),
        .fail_pulse (fail_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit ok;
        int at;
    } ev_t;

    ev_t        sb[$];
    int         exp_dcnt[int];
    int         checks = 0;
    int         errors = 0;
    int         mon_start = 32'h7fff_ffff;

    // Reference model: attempt progress plus absolute cycle windows
    int         ndig = 0;
    bit         bad = 1'b0;
    int         last = 0;
    int         busy_until = 0;
    int         fails = 0;
    int         open_s = 0, open_e = 0;
    int         lock_s = 0, lock_e = 0;
    logic [3:0] prev = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int code_dig(input logic [7:0] code, input int i);
        logic [7:0] v;
        v = code >> (2 * (PW_LEN - 1 - i));
        return int'(v[1:0]);
    endfunction

    task automatic model_cycle(input logic [3:0] k, input bit r);
        int         c;
        int         d;
        bit         done;
        logic [3:0] rise;
        c    = cyc;
        done = 1'b0;
        if (r) begin
            ndig = 0;
            bad = 1'b0;
            fails = 0;
            prev = '0;
            busy_until = c + 1;
            if (open_e > c + 1) open_e = c + 1;
            if (lock_e > c + 1) lock_e = c + 1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at > c) sb.delete(i);
            end
            exp_dcnt[c + 1] = 0;
            if (mon_start > c) mon_start = c;
            return;
        end
        rise = k & ~prev;
        prev = k;
        if (ndig > 0 && c - last > T_ENTRY) begin
            ndig = 0;
            bad = 1'b0;
        end
        if (rise != 0 && c >= busy_until) begin
            d = 0;
            for (int i = 3; i >= 0; i--) if (rise[i]) d = i;
            if ($countones(rise) > 1 || d != code_dig(PW, ndig)) bad = 1'b1;
            ndig++;
            last = c;
            if (ndig == PW_LEN) begin
                done = 1'b1;
                if (!bad) begin
                    sb.push_back('{ok: 1'b1, at: c + 2});
                    open_s = c + 2;
                    open_e = c + 2 + T_OPEN;
                    busy_until = open_e;
                    fails = 0;
                end else begin
                    sb.push_back('{ok: 1'b0, at: c + 2});
                    fails++;
                    if (LOCK_EN && fails >= MAX_FAIL) begin
                        lock_s = c + 3;
                        lock_e = c + 3 + T_LOCKOUT;
                        busy_until = lock_e;
                        fails = 0;
                    end else begin
                        busy_until = c + 3;
                    end
                end
                ndig = 0;
                bad = 1'b0;
            end
        end
        if (done) exp_dcnt[c + 1] = PW_LEN;
        else if (ndig > 0 && c + 1 - last > T_ENTRY) exp_dcnt[c + 1] = 0;
        else exp_dcnt[c + 1] = ndig;
    endtask

    task automatic step(input logic [3:0] k, input bit r);
        @(posedge clk);
        #1;
        key = k;
        rst = r;
        model_cycle(k, r);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, 1'b0);
    endtask

    task automatic press(input logic [3:0] m, input int gap);
        step(m, 1'b0);
        idle(gap);
    endtask

    task automatic enter_code(input logic [7:0] code, input int gap);
        for (int i = 0; i < PW_LEN; i++) press(4'b0001 << code_dig(code, i), gap);
    endtask

    // Monitor: per-cycle level checks and scoreboard pops on every pulse
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (cyc > mon_start) begin
                chk("unlock", int'(unlock), int'(cyc >= open_s && cyc < open_e));
                chk("alarm", int'(alarm), int'(cyc >= lock_s && cyc < lock_e));
                if (exp_dcnt.exists(cyc)) begin
                    chk("digit_cnt", int'(digit_cnt), exp_dcnt[cyc]);
                    exp_dcnt.delete(cyc);
                end
                while (sb.size() > 0 && sb[0].at < cyc) begin
                    chk("pulse_missed", cyc, sb[0].at);
                    void'(sb.pop_front());
                end
                if (ok_pulse || fail_pulse) begin
                    if (sb.size() == 0) begin
                        chk("spurious_pulse", int'(ok_pulse) + int'(fail_pulse), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("ok_pulse", int'(ok_pulse), int'(e.ok));
                        chk("fail_pulse", int'(fail_pulse), int'(!e.ok));
                        chk("pulse_cycle", cyc, e.at);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int         r;
        int         hold;
        int         gap;
        logic [3:0] m;
        rst = 1'b1;
        key = '0;
        repeat (3) step(4'b0000, 1'b1);

        enter_code(PW, 5);
        idle(20);

        repeat (3) begin
            enter_code(WRONG, 5);
            idle(5);
        end
        idle(40);
        enter_code(PW, 5);
        idle(20);

        press(4'b0001, 3);
        press(4'b0010, 3);
        idle(25);
        enter_code(PW, 5);
        idle(20);

        press(4'b0011, 5);
        press(4'b0010, 5);
        press(4'b0100, 5);
        press(4'b1000, 5);
        idle(10);

        enter_code(PW, 1);
        for (int i = 0; i < 20; i++) step((i < 8 && i % 3 == 0) ? 4'b1001 : 4'b1000, 1'b0);
        idle(25);

        press(4'b0001, 3);
        press(4'b0010, 3);
        step(4'b0000, 1'b1);
        idle(5);
        enter_code(PW, 5);
        idle(15);

        repeat (3) begin
            enter_code(WRONG, 3);
            idle(3);
        end
        idle(10);
        step(4'b0000, 1'b1);
        idle(3);
        repeat (2) begin
            enter_code(WRONG, 3);
            idle(3);
        end
        enter_code(PW, 3);
        idle(15);

        repeat (5) begin
            enter_code(WRONG, 3);
            idle(3);
        end
        idle(40);

        repeat (400) begin
            r = $urandom_range(0, 19);
            if (r < 12) m = 4'b0001 << code_dig(PW, ndig % PW_LEN);
            else if (r < 17) m = 4'b0001 << $urandom_range(0, 3);
            else m = 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 3);
            gap = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 22) : $urandom_range(0, 6);
            repeat (hold) step(m, 1'b0);
            idle(gap);
        end

        idle(60);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
